clk_step_ctrl: RTL and testbench

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

---
 rtl/clk_ctrl_pkg.sv | 20 ++
 rtl/clk_prescaler.sv | 42 ++++
 rtl/clk_step_ctrl.sv | 124 ++++++++++++
 tb/tb_clk_step_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the core clock-step controller.
// Holds the controller state encoding and the default widths of the
// step counter and the prescaler ratio.  No ports; imported by
// clk_prescaler and clk_step_ctrl.
package clk_ctrl_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DIV_W_DEF = 8;

    localparam logic [1:0] ENC_HALTED = 2'd0;
    localparam logic [1:0] ENC_RUN    = 2'd1;
    localparam logic [1:0] ENC_STEP   = 2'd2;

    typedef enum logic [1:0] {
        HALTED = ENC_HALTED,
        RUN    = ENC_RUN,
        STEP   = ENC_STEP
    } state_t;

endpackage

// File: rtl/clk_prescaler.sv
// Programmable prescaler that paces the core clock-enable.
// Counts 0..ratio while enabled and wraps back to 0; tick is high in
// the cycle where the count equals ratio.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   en    - advance the count this cycle
//   clr   - force the count back to 0 (wins over en)
//   ratio - terminal count (enable period minus one)
//   tick  - count has reached ratio
module clk_prescaler
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] ratio,
    output logic             tick
);

    logic [DIV_W-1:0] pcnt;

    // Tick is decoded from the count register only, so the enable it
    // produces downstream carries no combinational path from inputs.
    assign tick = (pcnt == ratio);

    // The counter restarts from 0 whenever it is cleared, so the first
    // tick after a clear lands exactly ratio+1 cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/step/halt controller producing the clock-enable for a core datapath.
// The core either free-runs (RUN), executes a counted burst of enables
// (STEP) or is stopped (HALTED).  Enables are spaced div_ratio+1 cycles
// apart by a prescaler; the period is latched on entry to RUN or STEP.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   run_req    - level, request free-running enables
//   halt_req   - pulse, stop all enables (highest priority)
//   step_req   - pulse, start a burst of step_n enables
//   step_n     - burst length, sampled with step_req
//   div_ratio  - enable period minus one, sampled on RUN/STEP entry
//   cpu_ce     - clock enable to the core
//   step_done  - one-cycle pulse when a burst completes
//   steps_left - enables remaining in the current/aborted burst
//   halted     - controller is in HALTED
//   busy       - controller is in RUN or STEP
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic [CNT_W-1:0] step_n,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             cpu_ce,
    output logic             step_done,
    output logic [CNT_W-1:0] steps_left,
    output logic             halted,
    output logic             busy
);

    state_t           state;
    logic [DIV_W-1:0] div_latched;
    logic             tick;
    logic             active;
    logic             last_step;
    logic             leaving;
    logic             ps_clr;

    // Status and enable are pure decodes of registered state, so cpu_ce
    // drops as soon as reset forces the state back to HALTED.
    assign active    = (state == RUN) || (state == STEP);
    assign cpu_ce    = active && tick;
    assign busy      = active;
    assign halted    = (state == HALTED);
    assign last_step = (state == STEP) && tick && (steps_left <= CNT_W'(1));

    // The prescaler is also cleared on the edge that leaves RUN/STEP so
    // the count already reads 0 in the first HALTED cycle.
    assign leaving = ((state == RUN)  && (halt_req || !run_req)) ||
                     ((state == STEP) && (halt_req || last_step));
    assign ps_clr  = (state == HALTED) || leaving;

    clk_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (active),
        .clr   (ps_clr),
        .ratio (div_latched),
        .tick  (tick)
    );

    // Main controller.  HALTED arbitrates halt > step > run; RUN and STEP
    // ignore new step/run requests.  An enable that coincides with a halt
    // still consumes a step, but an aborted burst never reports done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HALTED;
            steps_left  <= '0;
            div_latched <= '0;
            step_done   <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state)
                HALTED: begin
                    if (halt_req) begin
                        state <= HALTED;
                    end else if (step_req) begin
                        if (step_n != '0) begin
                            state       <= STEP;
                            steps_left  <= step_n;
                            div_latched <= div_ratio;
                        end else begin
                            step_done <= 1'b1;
                        end
                    end else if (run_req) begin
                        state       <= RUN;
                        div_latched <= div_ratio;
                    end
                end
                RUN: begin
                    if (halt_req || !run_req) begin
                        state <= HALTED;
                    end
                end
                STEP: begin
                    if (halt_req) begin
                        state <= HALTED;
                        if (cpu_ce && (steps_left != '0)) begin
                            steps_left <= steps_left - CNT_W'(1);
                        end
                    end else if (last_step) begin
                        state      <= HALTED;
                        steps_left <= '0;
                        step_done  <= 1'b1;
                    end else if (cpu_ce) begin
                        steps_left <= steps_left - CNT_W'(1);
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Self-checking bench for clk_step_ctrl.  Operations compute their
// expected enable/done events with plain arithmetic and queue them; a
// monitor pops one record per output event and compares it.
module tb_clk_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic [15:0] step_n = '0;
    logic [7:0]  div_ratio = '0;
    logic        cpu_ce;
    logic        step_done;
    logic [15:0] steps_left;
    logic        halted;
    logic        busy;

    typedef struct {
        int cyc;
        bit ce;
        bit done;
        int left;
    } ev_t;

    ev_t expq[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  mleft = 0;

    clk_step_ctrl #(
        .CNT_W (16),
        .DIV_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .step_n     (step_n),
        .div_ratio  (div_ratio),
        .cpu_ce     (cpu_ce),
        .step_done  (step_done),
        .steps_left (steps_left),
        .halted     (halted),
        .busy       (busy)
    );

    // 10-time-unit clock
    always #5 clk = ~clk;

    // Cycle index shared by the stimulus and the monitor
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every enable or done pulse must match the next queued event
    always @(negedge clk) begin
        ev_t e;
        if (!rst && (cpu_ce !== 1'b0 || step_done !== 1'b0)) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_event: cyc=%0d ce=%b done=%b left=%0d, expected no event",
                         cyc, cpu_ce, step_done, steps_left);
            end else begin
                e = expq.pop_front();
                if (e.cyc != cyc || cpu_ce !== e.ce || step_done !== e.done ||
                    int'(steps_left) != e.left) begin
                    fails++;
                    $display("[TB] FAIL event: got cyc=%0d ce=%b done=%b left=%0d, expected cyc=%0d ce=%b done=%b left=%0d",
                             cyc, cpu_ce, step_done, steps_left, e.cyc, e.ce, e.done, e.left);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit h, input int n, input int d);
        run_req   = r;
        step_req  = s;
        halt_req  = h;
        step_n    = 16'(n);
        div_ratio = 8'(d);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushEv(input int c, input bit ce, input bit done, input int left);
        ev_t e;
        e.cyc = c; e.ce = ce; e.done = done; e.left = left;
        expq.push_back(e);
    endtask

    // Wait for all queued events to be seen, then idle a few cycles
    task automatic drain();
        int b = 0;
        while (expq.size() != 0 && b < 400) begin
            nextCycle();
            b++;
        end
        checkOutput("pending_events", expq.size(), 0);
        expq.delete();
        repeat (3) nextCycle();
    endtask

    task automatic postChecks(input string tag);
        checkOutput({tag, "_halted"}, int'(halted), 1);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_cpu_ce"}, int'(cpu_ce), 0);
        checkOutput({tag, "_steps_left"}, int'(steps_left), mleft);
    endtask

    // Burst of n enables with period d+1; off>0 issues halt_req off cycles
    // after the request cycle.
    task automatic stepOp(input int n, input int d, input int off);
        int p, last, kmax, limit;
        nextCycle();
        p = cyc;
        last = p + n * (d + 1);
        applyStimulus(0, 1, 0, n, d);
        if (n == 0) begin
            pushEv(p + 1, 0, 1, mleft);
        end else begin
            kmax = (off == 0) ? n : off / (d + 1);
            if (kmax > n) kmax = n;
            for (int k = 1; k <= kmax; k++) pushEv(p + k * (d + 1), 1, 0, n - k + 1);
            if (off == 0) begin
                pushEv(last + 1, 0, 1, 0);
                mleft = 0;
            end else begin
                mleft = n - kmax;
            end
        end
        nextCycle();
        applyStimulus(0, 0, 0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)));
        if (n != 0) begin
            limit = (off == 0) ? last : p + off;
            while (cyc < limit) begin
                step_req = 1'($urandom_range(0, 1));
                nextCycle();
            end
            step_req = 1'b0;
            if (off != 0) begin
                halt_req = 1'b1;
                nextCycle();
                halt_req = 1'b0;
            end
        end
        drain();
        postChecks("step");
    endtask

    // Free-run with period d+1 for L cycles, ended by run_req low or halt
    task automatic runOp(input int d, input int len, input bit use_halt);
        int p;
        nextCycle();
        p = cyc;
        applyStimulus(1, 0, 0, 0, d);
        for (int k = 1; k * (d + 1) <= len; k++) pushEv(p + k * (d + 1), 1, 0, mleft);
        while (cyc < p + len) begin
            nextCycle();
            step_req  = 1'($urandom_range(0, 1));
            step_n    = 16'($urandom_range(1, 9));
            div_ratio = 8'($urandom_range(0, 255));
        end
        step_req = 1'b0;
        run_req  = use_halt;
        halt_req = use_halt;
        nextCycle();
        checkOutput("run_exit_halted", int'(halted), 1);
        applyStimulus(0, 0, 0, 0, 0);
        drain();
        postChecks("run");
    endtask

    // Eight-step burst interrupted by an asynchronous reset
    task automatic rstOp(input int d);
        int p, r;
        nextCycle();
        p = cyc;
        r = p + int'($urandom_range(1, 8 * (d + 1)));
        applyStimulus(0, 1, 0, 8, d);
        for (int k = 1; p + k * (d + 1) < r; k++) pushEv(p + k * (d + 1), 1, 0, 8 - k + 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        while (cyc < r) nextCycle();
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_cpu_ce", int'(cpu_ce), 0);
        checkOutput("rst_steps_left", int'(steps_left), 0);
        checkOutput("rst_halted", int'(halted), 1);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        mleft = 0;
        drain();
        postChecks("rst");
    endtask

    initial begin
        int n, d, op;
        repeat (2) nextCycle();
        checkOutput("reset_halted", int'(halted), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_cpu_ce", int'(cpu_ce), 0);
        checkOutput("reset_step_done", int'(step_done), 0);
        checkOutput("reset_steps_left", int'(steps_left), 0);
        rst = 1'b0;
        nextCycle();

        stepOp(5, 0, 0);
        runOp(3, 20, 1'b0);
        stepOp(10, 1, 6);
        checkOutput("abort_steps_left", int'(steps_left), 7);
        stepOp(0, 2, 0);

        // All three requests together: halt wins, nothing happens
        nextCycle();
        applyStimulus(1, 1, 1, 4, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) nextCycle();
        checkOutput("all_req_halted", int'(halted), 1);
        checkOutput("all_req_busy", int'(busy), 0);

        // Step and run together: step wins
        begin
            int p;
            nextCycle();
            p = cyc;
            applyStimulus(1, 1, 0, 2, 0);
            pushEv(p + 1, 1, 0, 2);
            pushEv(p + 2, 1, 0, 1);
            pushEv(p + 3, 0, 1, 0);
            mleft = 0;
            nextCycle();
            checkOutput("step_run_busy", int'(busy), 1);
            applyStimulus(0, 0, 0, 0, 0);
            drain();
            postChecks("step_run");
        end

        rstOp(0);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            d  = int'($urandom_range(0, 3));
            n  = int'($urandom_range(0, 6));
            case (op)
                0: stepOp(n, d, 0);
                1: stepOp(n, d, (n == 0) ? 0 : int'($urandom_range(1, n * (d + 1))));
                2: runOp(d, int'($urandom_range(1, 16)), 1'($urandom_range(0, 1)));
                default: rstOp(d);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
